// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending controller with timed dispense and change return
module vend_sequencer #(
  parameter int PRICE0      = 15,
  parameter int PRICE1      = 20,
  parameter int PRICE2      = 25,
  parameter int PRICE3      = 35,
  parameter int MAX_CREDIT  = 95,
  parameter int DISP_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       COIN5,
  input  logic       COIN10,
  input  logic       COIN25,
  input  logic [1:0] SEL,
  input  logic       BUY,
  input  logic       CANCEL,
  input  logic [3:0] STOCK,
  output logic [3:0] EN,
  output logic       CHG5,
  output logic       REJECT,
  output logic       ERR,
  output logic [7:0] CREDIT,
  output logic       BUSY
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  state_t     state, next_state;
  logic [7:0] credit, next_credit, cnt, next_cnt;
  logic [1:0] sel_q, next_sel;
  logic       rej_q, err_q, next_rej, next_err;
  logic [8:0] coin_sum, price, total;
  logic       active, cancel_go, over, coin_any, buy_ok;

  // per-cycle coin total, selected price and purchase/cancel decisions
  always_comb begin
    coin_sum  = (COIN5 ? 9'd5 : 9'd0) + (COIN10 ? 9'd10 : 9'd0) + (COIN25 ? 9'd25 : 9'd0);
    price     = SEL == 2'd0 ? 9'(PRICE0) : SEL == 2'd1 ? 9'(PRICE1) : SEL == 2'd2 ? 9'(PRICE2) : 9'(PRICE3);
    total     = {1'b0, credit} + coin_sum;
    active    = state == IDLE || state == COLLECT;
    cancel_go = state == COLLECT && CANCEL;
    over      = total > 9'(MAX_CREDIT);
    coin_any  = COIN5 | COIN10 | COIN25;
    buy_ok    = active && !cancel_go && BUY && {1'b0, credit} >= price && STOCK[SEL];
  end

  // next state and datapath; the overflow test uses pre-purchase credit
  always_comb begin
    next_state  = state;
    next_credit = credit;
    next_cnt    = cnt;
    next_sel    = sel_q;
    next_rej    = coin_any && (!active || cancel_go || over);
    next_err    = active && !cancel_go && BUY && !buy_ok;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_go) next_state = CHANGE;
        else begin
          next_credit = 8'(total - (over ? coin_sum : 9'd0) - (buy_ok ? price : 9'd0));
          next_state  = buy_ok ? DISPENSE : (next_credit != 8'd0 ? COLLECT : IDLE);
          next_cnt    = buy_ok ? 8'd0 : cnt;
          next_sel    = buy_ok ? SEL : sel_q;
        end
      end
      DISPENSE: begin
        next_cnt = cnt + 8'd1;
        if (cnt == 8'(DISP_CYCLES - 1)) next_state = credit != 8'd0 ? CHANGE : IDLE;
      end
      default: begin
        next_credit = credit <= 8'd5 ? 8'd0 : credit - 8'd5;
        next_state  = credit <= 8'd5 ? IDLE : CHANGE;
      end
    endcase
  end

  // state register with synchronous active-low reset discarding any credit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      credit <= 8'd0;
      cnt    <= 8'd0;
      sel_q  <= 2'd0;
      rej_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      credit <= next_credit;
      cnt    <= next_cnt;
      sel_q  <= next_sel;
      rej_q  <= next_rej;
      err_q  <= next_err;
    end
  end

  // outputs decoded from state; REJECT/ERR report the previous edge's decision
  always_comb begin
    EN     = state == DISPENSE ? 4'b0001 << sel_q : 4'b0000;
    CHG5   = state == CHANGE;
    BUSY   = state == DISPENSE || state == CHANGE;
    REJECT = rej_q;
    ERR    = err_q;
    CREDIT = credit;
  end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scoreboard bench with behavioural vending model plus directed scenarios
module tb_vend_sequencer;
  localparam int MAXC = 95;
  localparam int DISP = 4;
  localparam int F_EN = 0, F_CHG5 = 1, F_REJ = 2, F_ERR = 3, F_CREDIT = 4, F_BUSY = 5;

  typedef struct packed {
    logic [3:0] en;
    logic       chg5;
    logic       reject;
    logic       err;
    logic [7:0] credit;
    logic       busy;
  } out_t;

  typedef struct {
    int    edge_n;
    int    f;
    int    v;
    string nm;
  } dchk_t;

  logic       CLK, RST_N, COIN5, COIN10, COIN25, BUY, CANCEL;
  logic [1:0] SEL;
  logic [3:0] STOCK, EN;
  logic       CHG5, REJECT, ERR, BUSY;
  logic [7:0] CREDIT;

  int    price_tab [4] = '{15, 20, 25, 35};
  out_t  q [$];
  dchk_t dq [$];
  int    checks = 0, failures = 0, m_edge = 0, n_edges = 0;
  int    m_credit = 0, m_disp_left = 0, m_item = 0;
  bit    m_chg = 0, m_rej = 0, m_err = 0;

  vend_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .COIN5(COIN5), .COIN10(COIN10), .COIN25(COIN25),
    .SEL(SEL), .BUY(BUY), .CANCEL(CANCEL), .STOCK(STOCK),
    .EN(EN), .CHG5(CHG5), .REJECT(REJECT), .ERR(ERR), .CREDIT(CREDIT), .BUSY(BUSY)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // reference: predicts outputs after the coming edge from the inputs now driven
  task automatic model_step();
    int   sum, add;
    bit   coins, over;
    out_t e;
    sum   = (COIN5 ? 5 : 0) + (COIN10 ? 10 : 0) + (COIN25 ? 25 : 0);
    coins = COIN5 | COIN10 | COIN25;
    m_rej = 0;
    m_err = 0;
    if (!RST_N) begin
      m_credit = 0; m_disp_left = 0; m_chg = 0;
    end else if (m_disp_left > 0) begin
      m_rej = coins;
      m_disp_left--;
      if (m_disp_left == 0 && m_credit > 0) m_chg = 1;
    end else if (m_chg) begin
      m_rej = coins;
      m_credit -= 5;
      if (m_credit == 0) m_chg = 0;
    end else if (CANCEL && m_credit > 0) begin
      m_rej = coins;
      m_chg = 1;
    end else begin
      over  = m_credit + sum > MAXC;
      m_rej = coins && over;
      add   = over ? 0 : sum;
      if (BUY && m_credit >= price_tab[SEL] && STOCK[SEL]) begin
        m_credit    = m_credit - price_tab[SEL] + add;
        m_disp_left = DISP;
        m_item      = int'(SEL);
      end else begin
        m_err    = BUY;
        m_credit = m_credit + add;
      end
    end
    e.en     = m_disp_left > 0 ? 4'b0001 << m_item : 4'b0000;
    e.chg5   = m_chg;
    e.reject = m_rej;
    e.err    = m_err;
    e.credit = 8'(m_credit);
    e.busy   = m_disp_left > 0 || m_chg;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [2:0] c, input logic [1:0] s, input logic b, input logic cn,
                     input logic [3:0] st, input logic rn);
    @(posedge CLK);
    n_edges++;
    #3;
    {COIN25, COIN10, COIN5} = c;
    SEL = s; BUY = b; CANCEL = cn; STOCK = st; RST_N = rn;
    model_step();
  endtask

  task automatic idle();
    cyc(3'b000, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 25; i++) cyc(3'b000, 2'd0, 1'b0, (i == 0), 4'hF, 1'b1);
  endtask

  task automatic chk_next(input int f, input int v, input string nm);
    dchk_t d;
    d.edge_n = n_edges + 1; d.f = f; d.v = v; d.nm = nm;
    dq.push_back(d);
  endtask

  function automatic int field(input int f);
    return f == F_EN ? int'(EN) : f == F_CHG5 ? int'(CHG5) : f == F_REJ ? int'(REJECT) :
           f == F_ERR ? int'(ERR) : f == F_CREDIT ? int'(CREDIT) : int'(BUSY);
  endfunction

  // monitor: compares DUT against model and directed expectations after each edge
  always @(posedge CLK) begin
    out_t g, e;
    int   got;
    m_edge++;
    #2;
    g = '{EN, CHG5, REJECT, ERR, CREDIT, BUSY};
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL model edge %0d got en=%b chg5=%b rej=%b err=%b credit=%0d busy=%b exp en=%b chg5=%b rej=%b err=%b credit=%0d busy=%b",
                 m_edge, g.en, g.chg5, g.reject, g.err, g.credit, g.busy,
                 e.en, e.chg5, e.reject, e.err, e.credit, e.busy);
      end
    end
    while (dq.size() > 0 && dq[0].edge_n <= m_edge) begin
      dchk_t d;
      d = dq.pop_front();
      got = field(d.f);
      checks++;
      if (d.edge_n != m_edge || got != d.v) begin
        failures++;
        $display("FAIL %s edge %0d got=%0d exp=%0d", d.nm, m_edge, got, d.v);
      end
    end
  end

  initial begin
    logic [3:0] stock;
    stock = 4'hF;
    {COIN25, COIN10, COIN5} = 3'b000;
    SEL = 2'd0; BUY = 0; CANCEL = 0; STOCK = 4'hF; RST_N = 0;
    model_step();
    chk_next(F_CREDIT, 0, "rst_credit"); chk_next(F_EN, 0, "rst_en");
    chk_next(F_BUSY, 0, "rst_busy"); chk_next(F_CHG5, 0, "rst_chg5");
    cyc(3'b000, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0);
    chk_next(F_REJ, 0, "rst_rej"); chk_next(F_ERR, 0, "rst_err");
    idle();
    // two dimes, buy item 0, four dispense cycles, one nickel back
    cyc(3'b010, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b010, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    chk_next(F_CREDIT, 20, "r37_credit20");
    cyc(3'b000, 2'd0, 1'b1, 1'b0, 4'hF, 1'b1);
    chk_next(F_CREDIT, 5, "r37_credit5");
    for (int i = 0; i < DISP; i++) begin
      chk_next(F_EN, 1, "r37_en");
      idle();
    end
    chk_next(F_EN, 0, "r37_en_off"); chk_next(F_CHG5, 1, "r37_chg5");
    idle();
    chk_next(F_CHG5, 0, "r37_chg5_off"); chk_next(F_CREDIT, 0, "r37_credit0"); chk_next(F_BUSY, 0, "r37_busy0");
    idle();
    // nickel, unaffordable buy, cancel
    cyc(3'b001, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b000, 2'd3, 1'b1, 1'b0, 4'hF, 1'b1);
    chk_next(F_ERR, 1, "r38_err"); chk_next(F_CREDIT, 5, "r38_credit5");
    cyc(3'b000, 2'd0, 1'b0, 1'b1, 4'hF, 1'b1);
    chk_next(F_CHG5, 1, "r38_chg5");
    idle();
    chk_next(F_CREDIT, 0, "r38_credit0"); chk_next(F_CHG5, 0, "r38_chg5_off");
    idle();
    // saturation at 95
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b011, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    chk_next(F_CREDIT, 90, "r39_credit90");
    cyc(3'b010, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    chk_next(F_REJ, 1, "r39_reject"); chk_next(F_CREDIT, 90, "r39_hold90");
    cyc(3'b001, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    chk_next(F_CREDIT, 95, "r39_credit95"); chk_next(F_REJ, 0, "r39_accept");
    drain();
    // out-of-stock buy with a coin in the same cycle
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b011, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    chk_next(F_CREDIT, 40, "r40_credit40");
    cyc(3'b001, 2'd2, 1'b1, 1'b0, 4'b1011, 1'b1);
    chk_next(F_ERR, 1, "r40_err"); chk_next(F_EN, 0, "r40_no_en"); chk_next(F_CREDIT, 45, "r40_credit45");
    drain();
    // buy and cancel together: cancel wins, five nickels returned
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b000, 2'd0, 1'b1, 1'b1, 4'hF, 1'b1);
    chk_next(F_ERR, 0, "r41_no_err"); chk_next(F_EN, 0, "r41_no_en"); chk_next(F_CREDIT, 25, "r41_credit25");
    for (int i = 0; i < 5; i++) begin
      chk_next(F_CHG5, 1, "r41_chg5");
      idle();
    end
    chk_next(F_CHG5, 0, "r41_chg5_off"); chk_next(F_CREDIT, 0, "r41_credit0");
    idle();
    // reset in the middle of a dispense
    cyc(3'b100, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1);
    cyc(3'b000, 2'd0, 1'b1, 1'b0, 4'hF, 1'b1);
    chk_next(F_EN, 1, "r42_en"); chk_next(F_CREDIT, 10, "r42_credit10");
    idle();
    cyc(3'b000, 2'd0, 1'b0, 1'b0, 4'hF, 1'b0);
    chk_next(F_EN, 0, "r42_en_off"); chk_next(F_CREDIT, 0, "r42_credit0"); chk_next(F_BUSY, 0, "r42_busy0");
    idle();
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) stock = 4'($urandom);
      cyc({$urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0},
          2'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, stock,
          $urandom_range(0, 299) != 0);
    end
    idle();
    @(posedge CLK);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE0, default 15, price of item 0 in credit units (multiple of 5).
REQ-002 SHALL have parameter PRICE1, default 20, price of item 1.
REQ-003 SHALL have parameter PRICE2, default 25, price of item 2.
REQ-004 SHALL have parameter PRICE3, default 35, price of item 3.
REQ-005 SHALL have parameter MAX_CREDIT, default 95, credit saturation limit (multiple of 5, at most 255).
REQ-006 SHALL have parameter DISP_CYCLES, default 4, number of cycles the dispense enable is held (1 to 255).
REQ-007 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-008 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port COIN5  input  1  one-cycle pulse: 5-unit coin inserted.
REQ-010 SHALL have port COIN10  input  1  one-cycle pulse: 10-unit coin inserted.
REQ-011 SHALL have port COIN25  input  1  one-cycle pulse: 25-unit coin inserted.
REQ-012 SHALL have port SEL  input  2  item selection, sampled only when BUY=1.
REQ-013 SHALL have port BUY  input  1  one-cycle purchase request.
REQ-014 SHALL have port CANCEL  input  1  one-cycle refund request.
REQ-015 SHALL have port STOCK  input  4  per-item availability, 1 = in stock.
REQ-016 SHALL have port EN  output  4  one-hot dispense enable, ANDed downstream with the item coil command.
REQ-017 SHALL have port CHG5  output  1  one-cycle pulse per 5 units of change returned.
REQ-018 SHALL have port REJECT  output  1  one-cycle pulse: the coin(s) presented this cycle were refused.
REQ-019 SHALL have port ERR  output  1  one-cycle pulse: BUY refused (insufficient credit or out of stock).
REQ-020 SHALL have port CREDIT  output  8  current registered credit.
REQ-021 SHALL have port BUSY  output  1  high in DISPENSE and CHANGE.

Function
REQ-022 SHALL implement states IDLE (credit 0), COLLECT (credit > 0), DISPENSE and CHANGE.
REQ-023 SHALL, in IDLE/COLLECT, add the sum of all coin pulses in a cycle to CREDIT on the next edge; IDLE goes to COLLECT when the result is > 0.
REQ-024 SHALL, if credit + coin sum > MAX_CREDIT, refuse the entire cycle's coins: CREDIT unchanged, REJECT=1 for one cycle.
REQ-025 SHALL evaluate BUY against the pre-edge CREDIT and STOCK[SEL]: if CREDIT >= PRICE[SEL] and STOCK[SEL]=1, then CREDIT <= CREDIT - PRICE[SEL] + accepted coins, latch SEL, enter DISPENSE.
REQ-026 SHALL otherwise, on BUY, pulse ERR for one cycle and stay in the current state; accepted coins in that cycle are still added.
REQ-027 SHALL hold EN[latched SEL]=1 (others 0) for exactly DISP_CYCLES cycles in DISPENSE, starting the cycle after the accepting edge.
REQ-028 SHALL go from DISPENSE to CHANGE if remaining credit > 0, else to IDLE.
REQ-029 SHALL, in CHANGE, emit CHG5=1 and decrement CREDIT by 5 each cycle; transition to IDLE on the edge where CREDIT reaches 0.
REQ-030 SHALL, on CANCEL in COLLECT, enter CHANGE next cycle; CANCEL in IDLE is ignored; coins in the CANCEL cycle are REJECTed.
REQ-031 SHALL give CANCEL priority over BUY when both are asserted in the same cycle (no ERR, no dispense).
REQ-032 SHALL, in DISPENSE/CHANGE, ignore BUY and CANCEL, and REJECT any coin pulse.
REQ-033 SHALL never let CREDIT exceed MAX_CREDIT or underflow below 0.
REQ-034 SHALL treat STOCK changes during DISPENSE as having no effect on the dispense in progress.

Reset
REQ-035 SHALL, while RST_N=0 at a rising edge, enter IDLE with CREDIT=0, EN=0, CHG5=0, REJECT=0, ERR=0, BUSY=0, dispense counter cleared.
REQ-036 SHALL abort a dispense or change sequence on reset mid-operation (EN drops the cycle after the reset edge; unreturned credit is discarded).

Verification
REQ-037 COIN10, COIN10, BUY SEL=0 (price 15), STOCK=4'hF -> CREDIT 20, EN=4'b0001 for 4 cycles, then one CHG5 pulse, CREDIT 0, IDLE.
REQ-038 COIN5, BUY SEL=3 -> ERR pulse, CREDIT stays 5; CANCEL -> one CHG5, CREDIT 0.
REQ-039 CREDIT 90, COIN10 -> REJECT pulse, CREDIT 90; COIN5 -> CREDIT 95.
REQ-040 CREDIT 40, STOCK[2]=0, BUY SEL=2 -> ERR, no EN; same cycle COIN5 -> CREDIT 45.
REQ-041 BUY and CANCEL same cycle with CREDIT 25 -> no EN, no ERR, 5 CHG5 pulses.
REQ-042 RST_N=0 during DISPENSE cycle 2 -> next cycle EN=0, CREDIT=0, BUSY=0.
